// File: rtl/seq_add_ctrl.sv
// Sequential W-bit adder controller: drives an external 16-bit adder one word per cycle.
// Optional signed-overflow flag enabled by defining SEQ_ADD_OVF_EN.
module seq_add_ctrl #(
    parameter int WORDS = 2
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                in_valid,
    output logic                in_ready,
    input  logic [16*WORDS-1:0] a,
    input  logic [16*WORDS-1:0] b,
    input  logic                cin,
    output logic [15:0]         add_a,
    output logic [15:0]         add_b,
    output logic                add_cin,
    input  logic [15:0]         add_sum,
    input  logic                add_cout,
    output logic                out_valid,
    input  logic                out_ready,
    output logic [16*WORDS-1:0] sum,
    output logic                cout,
    output logic                ovf
);

    localparam int W = 16 * WORDS;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t        state_r;
    logic [1:0]    k_r;
    logic [W-17:0] a_sh_r;
    logic [W-17:0] b_sh_r;
    logic [15:0]   add_a_r;
    logic [15:0]   add_b_r;
    logic          add_cin_r;
    logic [W-1:0]  sum_r;
    logic          cout_r;
    logic          in_ready_r;
    logic          out_valid_r;
    logic          last_s;

    assign last_s    = (k_r == 2'(WORDS - 1));
    assign in_ready  = in_ready_r;
    assign out_valid = out_valid_r;
    assign add_a     = add_a_r;
    assign add_b     = add_b_r;
    assign add_cin   = add_cin_r;
    assign sum       = sum_r;
    assign cout      = cout_r;

    // Control FSM; the adder operand registers double as the carry register and
    // are preloaded one word ahead so the adder ports come straight from flops.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r     <= IDLE;
            k_r         <= 2'd0;
            a_sh_r      <= '0;
            b_sh_r      <= '0;
            add_a_r     <= 16'd0;
            add_b_r     <= 16'd0;
            add_cin_r   <= 1'b0;
            sum_r       <= '0;
            cout_r      <= 1'b0;
            in_ready_r  <= 1'b1;
            out_valid_r <= 1'b0;
        end else begin
            case (state_r)
                IDLE: begin
                    if (in_valid) begin
                        a_sh_r     <= a[W-1:16];
                        b_sh_r     <= b[W-1:16];
                        add_a_r    <= a[15:0];
                        add_b_r    <= b[15:0];
                        add_cin_r  <= cin;
                        k_r        <= 2'd0;
                        in_ready_r <= 1'b0;
                        state_r    <= CALC;
                    end
                end
                CALC: begin
                    for (int i = 0; i < WORDS; i++) begin
                        if (k_r == 2'(i)) begin
                            sum_r[16*i +: 16] <= add_sum;
                        end
                    end
                    if (last_s) begin
                        cout_r      <= add_cout;
                        add_a_r     <= 16'd0;
                        add_b_r     <= 16'd0;
                        add_cin_r   <= 1'b0;
                        k_r         <= 2'd0;
                        out_valid_r <= 1'b1;
                        state_r     <= DONE;
                    end else begin
                        add_a_r   <= a_sh_r[15:0];
                        add_b_r   <= b_sh_r[15:0];
                        a_sh_r    <= a_sh_r >> 5'd16;
                        b_sh_r    <= b_sh_r >> 5'd16;
                        add_cin_r <= add_cout;
                        k_r       <= k_r + 2'd1;
                    end
                end
                DONE: begin
                    if (out_ready) begin
                        out_valid_r <= 1'b0;
                        in_ready_r  <= 1'b1;
                        state_r     <= IDLE;
                    end
                end
                default: begin
                    state_r     <= IDLE;
                    k_r         <= 2'd0;
                    add_a_r     <= 16'd0;
                    add_b_r     <= 16'd0;
                    add_cin_r   <= 1'b0;
                    in_ready_r  <= 1'b1;
                    out_valid_r <= 1'b0;
                end
            endcase
        end
    end

`ifdef SEQ_ADD_OVF_EN
    logic a_msb_r;
    logic b_msb_r;
    logic ovf_r;

    // Overflow judged from the captured operand signs and the final sum word.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            a_msb_r <= 1'b0;
            b_msb_r <= 1'b0;
            ovf_r   <= 1'b0;
        end else if ((state_r == IDLE) && in_valid) begin
            a_msb_r <= a[W-1];
            b_msb_r <= b[W-1];
            ovf_r   <= 1'b0;
        end else if ((state_r == CALC) && last_s) begin
            ovf_r <= (a_msb_r == b_msb_r) && (add_sum[15] != a_msb_r);
        end
    end

    assign ovf = ovf_r;
`else
    assign ovf = 1'b0;
`endif

endmodule

// File: tb/tb_seq_add_ctrl.sv
// Self-checking bench for seq_add_ctrl (WORDS=2 and WORDS=4 instances), random and
// directed stimulus against an arithmetic reference model.
module tb_seq_add_ctrl;

`ifdef SEQ_ADD_OVF_EN
    localparam bit OVF_EN = 1'b1;
`else
    localparam bit OVF_EN = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    int          errors = 0;
    int          checks = 0;

    // WORDS=2 instance
    logic        in_valid = 1'b0, in_ready, cin = 1'b0, out_valid, out_ready = 1'b0;
    logic [31:0] a = 32'd0, b = 32'd0, sum;
    logic [15:0] add_a, add_b, add_sum;
    logic        add_cin, add_cout, cout, ovf;

    // WORDS=4 instance
    logic        in_valid4 = 1'b0, in_ready4, cin4 = 1'b0, out_valid4, out_ready4 = 1'b0;
    logic [63:0] a4 = 64'd0, b4 = 64'd0, sum4;
    logic [15:0] add_a4, add_b4, add_sum4;
    logic        add_cin4, add_cout4, cout4, ovf4;

    always #5 clk = ~clk;

    assign {add_cout, add_sum}   = {1'b0, add_a} + {1'b0, add_b} + {16'd0, add_cin};
    assign {add_cout4, add_sum4} = {1'b0, add_a4} + {1'b0, add_b4} + {16'd0, add_cin4};

    seq_add_ctrl #(.WORDS(2)) dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
        .a(a), .b(b), .cin(cin), .add_a(add_a), .add_b(add_b), .add_cin(add_cin),
        .add_sum(add_sum), .add_cout(add_cout), .out_valid(out_valid),
        .out_ready(out_ready), .sum(sum), .cout(cout), .ovf(ovf)
    );

    seq_add_ctrl #(.WORDS(4)) dut4 (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid4), .in_ready(in_ready4),
        .a(a4), .b(b4), .cin(cin4), .add_a(add_a4), .add_b(add_b4), .add_cin(add_cin4),
        .add_sum(add_sum4), .add_cout(add_cout4), .out_valid(out_valid4),
        .out_ready(out_ready4), .sum(sum4), .cout(cout4), .ovf(ovf4)
    );

    function automatic logic [32:0] ref_add(input logic [31:0] x, input logic [31:0] y, input logic c);
        return {1'b0, x} + {1'b0, y} + {32'd0, c};
    endfunction

    function automatic logic ref_ovf(input logic [31:0] x, input logic [31:0] y, input logic c);
        longint r;
        r = longint'($signed(x)) + longint'($signed(y)) + longint'(c);
        return OVF_EN && ((r > 64'sd2147483647) || (r < -64'sd2147483648));
    endfunction

    // Runs one transaction on the WORDS=2 instance; scrambles inputs while busy.
    task automatic do_op(input logic [31:0] ta, input logic [31:0] tb_, input logic tc,
                         output logic [31:0] s, output logic c, output logic o,
                         output int lat, output logic [7:0] cins);
        @(negedge clk);
        a = ta; b = tb_; cin = tc; in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0; a = $urandom; b = $urandom; cin = 1'($urandom_range(0, 1));
        lat = 0;
        cins = 8'd0;
        cins[0] = add_cin;
        while (!out_valid && lat < 20) begin
            @(posedge clk); #1;
            lat++;
            if (!out_valid && lat < 8) cins[lat] = add_cin;
            in_valid = 1'($urandom_range(0, 1));
            a = $urandom; b = $urandom;
        end
        if (lat >= 20) lat = -1;
        s = sum; c = cout; o = ovf;
        in_valid = 1'b0; out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_out_valid got=%b exp=0", out_valid); end
        checks++; if (sum !== 32'd0 || cout !== 1'b0) begin errors++; $display("FAIL reset_sum got=%h/%b exp=0/0", sum, cout); end
        checks++; if (ovf !== 1'b0) begin errors++; $display("FAIL reset_ovf got=%b exp=0", ovf); end
        checks++; if (add_a !== 16'd0 || add_b !== 16'd0 || add_cin !== 1'b0) begin
            errors++; $display("FAIL reset_adder_ports got=%h/%h/%b exp=0", add_a, add_b, add_cin); end
        @(negedge clk); rst_n = 1'b1;
        @(posedge clk); #1;
        checks++; if (in_ready !== 1'b1 || in_ready4 !== 1'b1) begin
            errors++; $display("FAIL reset_in_ready got=%b/%b exp=1/1", in_ready, in_ready4); end
    endtask

    task automatic test_directed();
        logic [31:0] s; logic c, o; int lat; logic [7:0] cins;
        do_op(32'h0000FFFF, 32'h00000001, 1'b0, s, c, o, lat, cins);
        checks++; if (s !== 32'h00010000 || c !== 1'b0) begin errors++; $display("FAIL dir_carry_word got=%h/%b exp=00010000/0", s, c); end
        checks++; if (lat !== 2) begin errors++; $display("FAIL dir_latency got=%0d exp=2", lat); end
        checks++; if (cins[1:0] !== 2'b10) begin errors++; $display("FAIL dir_add_cin got=%b exp=10", cins[1:0]); end
        do_op(32'hFFFFFFFF, 32'h00000000, 1'b1, s, c, o, lat, cins);
        checks++; if (s !== 32'h00000000 || c !== 1'b1) begin errors++; $display("FAIL dir_wrap got=%h/%b exp=00000000/1", s, c); end
        do_op(32'h7FFFFFFF, 32'h00000001, 1'b0, s, c, o, lat, cins);
        checks++; if (s !== 32'h80000000 || c !== 1'b0 || o !== OVF_EN) begin
            errors++; $display("FAIL dir_ovf got=%h/%b/%b exp=80000000/0/%b", s, c, o, OVF_EN); end
    endtask

    task automatic test_random();
        logic [31:0] s, ta, tb_; logic c, o, tc; int lat; logic [7:0] cins; logic [32:0] e;
        for (int n = 0; n < 30; n++) begin
            ta = $urandom; tb_ = $urandom; tc = 1'($urandom_range(0, 1));
            if (n % 5 == 0) ta[31] = tb_[31];
            e = ref_add(ta, tb_, tc);
            do_op(ta, tb_, tc, s, c, o, lat, cins);
            checks++;
            if (s !== e[31:0] || c !== e[32] || o !== ref_ovf(ta, tb_, tc) || lat !== 2) begin
                errors++;
                $display("FAIL rand_%0d a=%h b=%h cin=%b got=%h/%b/%b lat=%0d exp=%h/%b/%b lat=2",
                         n, ta, tb_, tc, s, c, o, lat, e[31:0], e[32], ref_ovf(ta, tb_, tc));
            end
        end
    endtask

    task automatic test_hold();
        logic [31:0] ta, tb_; logic [32:0] e; int lat;
        ta = $urandom; tb_ = $urandom;
        e = ref_add(ta, tb_, 1'b0);
        @(negedge clk); a = ta; b = tb_; cin = 1'b0; in_valid = 1'b1;
        @(posedge clk); #1; in_valid = 1'b0;
        lat = 0;
        while (!out_valid && lat < 20) begin @(posedge clk); #1; lat++; end
        checks++; if (lat !== 2) begin errors++; $display("FAIL hold_latency got=%0d exp=2", lat); end
        for (int i = 0; i < 5; i++) begin
            in_valid = ~in_valid; a = $urandom; b = $urandom; cin = ~cin;
            @(posedge clk); #1;
            checks++;
            if (sum !== e[31:0] || cout !== e[32] || out_valid !== 1'b1 || in_ready !== 1'b0 ||
                add_a !== 16'd0 || add_cin !== 1'b0) begin
                errors++;
                $display("FAIL hold_cycle_%0d got=%h/%b v=%b r=%b adda=%h exp=%h/%b v=1 r=0 adda=0",
                         i, sum, cout, out_valid, in_ready, add_a, e[31:0], e[32]);
            end
        end
        a = 32'd5; b = 32'd6; cin = 1'b0; in_valid = 1'b1; out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
        checks++; if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
            errors++; $display("FAIL hold_release got in_ready=%b out_valid=%b exp=1/0", in_ready, out_valid); end
        @(posedge clk); #1;
        in_valid = 1'b0;
        checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL hold_next_accept got in_ready=%b exp=0", in_ready); end
        lat = 0;
        while (!out_valid && lat < 20) begin @(posedge clk); #1; lat++; end
        checks++; if (sum !== 32'd11 || lat !== 2) begin errors++; $display("FAIL hold_next_result got=%h lat=%0d exp=0000000b lat=2", sum, lat); end
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
    endtask

    task automatic test_reset_abort();
        logic [31:0] s; logic c, o; int lat, seen; logic [7:0] cins;
        @(negedge clk); a = 32'h12345678; b = 32'h11111111; cin = 1'b0; in_valid = 1'b1;
        @(posedge clk); #1; in_valid = 1'b0;
        rst_n = 1'b0;
        #2;
        checks++;
        if (out_valid !== 1'b0 || sum !== 32'd0 || cout !== 1'b0 || ovf !== 1'b0 ||
            add_a !== 16'd0 || add_b !== 16'd0 || add_cin !== 1'b0 || in_ready !== 1'b1) begin
            errors++;
            $display("FAIL abort_outputs got v=%b sum=%h c=%b o=%b adda=%h addb=%h r=%b exp=0 and r=1",
                     out_valid, sum, cout, ovf, add_a, add_b, in_ready);
        end
        @(negedge clk); rst_n = 1'b1;
        seen = 0;
        repeat (4) begin @(posedge clk); #1; if (out_valid) seen++; end
        checks++; if (seen !== 0) begin errors++; $display("FAIL abort_no_result got=%0d valid cycles exp=0", seen); end
        do_op(32'd3, 32'd4, 1'b0, s, c, o, lat, cins);
        checks++; if (s !== 32'd7 || c !== 1'b0 || lat !== 2) begin
            errors++; $display("FAIL abort_followup got=%h/%b lat=%0d exp=00000007/0 lat=2", s, c, lat); end
    endtask

    task automatic test_words4();
        logic [63:0] ta, tb_; logic tc; logic [64:0] e; logic eo; int lat;
        for (int n = 0; n < 6; n++) begin
            if (n == 0) begin ta = 64'h0000FFFFFFFFFFFF; tb_ = 64'd1; tc = 1'b0; end
            else begin ta = {$urandom, $urandom}; tb_ = {$urandom, $urandom}; tc = 1'($urandom_range(0, 1)); end
            e = {1'b0, ta} + {1'b0, tb_} + {64'd0, tc};
            eo = OVF_EN && (ta[63] == tb_[63]) && (e[63] != ta[63]);
            @(negedge clk); a4 = ta; b4 = tb_; cin4 = tc; in_valid4 = 1'b1;
            @(posedge clk); #1;
            in_valid4 = 1'b0; a4 = {$urandom, $urandom}; b4 = {$urandom, $urandom};
            lat = 0;
            while (!out_valid4 && lat < 20) begin @(posedge clk); #1; lat++; end
            checks++;
            if (sum4 !== e[63:0] || cout4 !== e[64] || ovf4 !== eo || lat !== 4) begin
                errors++;
                $display("FAIL w4_%0d got=%h/%b/%b lat=%0d exp=%h/%b/%b lat=4",
                         n, sum4, cout4, ovf4, lat, e[63:0], e[64], eo);
            end
            out_ready4 = 1'b1;
            @(posedge clk); #1;
            out_ready4 = 1'b0;
        end
    endtask

    initial begin
        test_reset();
        test_directed();
        test_random();
        test_hold();
        test_reset_abort();
        test_words4();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/seq_add_ctrl.md
SEQ_ADD_CTRL -- requirements
Module: seq_add_ctrl

Interface
REQ-001 The block SHALL have parameter WORDS, default 2: number of 16-bit words per operand, legal range 2..4, operand width W = 16*WORDS.
REQ-002 The block SHALL have port clk, input, 1 bit: single clock, all state updates on rising edge.
REQ-003 The block SHALL have port rst_n, input, 1 bit: asynchronous reset, active-low.
REQ-004 The block SHALL have port in_valid, input, 1 bit: operand request valid.
REQ-005 The block SHALL have port in_ready, output, 1 bit: block can accept operands.
REQ-006 The block SHALL have ports a and b, input, W bits each: addends.
REQ-007 The block SHALL have port cin, input, 1 bit: carry-in.
REQ-008 The block SHALL have port add_a and add_b, output, 16 bits each: word operands to the external 16-bit carry-select adder.
REQ-009 The block SHALL have port add_cin, output, 1 bit: carry to the external adder.
REQ-010 The block SHALL have port add_sum, input, 16 bits: combinational sum returned by the external adder.
REQ-011 The block SHALL have port add_cout, input, 1 bit: combinational carry returned by the external adder.
REQ-012 The block SHALL have port out_valid, output, 1 bit: result valid.
REQ-013 The block SHALL have port out_ready, input, 1 bit: consumer accepts result.
REQ-014 The block SHALL have port sum, output, W bits: registered result.
REQ-015 The block SHALL have port cout, output, 1 bit: registered final carry.
REQ-016 The block SHALL have port ovf, output, 1 bit: signed overflow flag (see Configuration).

Function
REQ-017 The FSM SHALL have states IDLE, CALC and DONE.
REQ-018 in_ready SHALL be 1 only in IDLE; out_valid SHALL be 1 only in DONE.
REQ-019 On in_valid && in_ready in IDLE, the block SHALL register a, b and cin, clear word index k to 0 and enter CALC.
REQ-020 In CALC, add_a/add_b SHALL be word k of the registered a/b, and add_cin SHALL be registered cin when k=0, else the carry captured in the previous CALC cycle.
REQ-021 Each CALC edge SHALL store add_sum into sum[16k+15:16k], store add_cout into the carry register and increment k.
REQ-022 After the edge storing word WORDS-1, the block SHALL enter DONE with cout equal to the last add_cout; out_valid therefore rises exactly WORDS cycles after the accepting edge.
REQ-023 sum and cout SHALL be stable while out_valid=1 and out_ready=0.
REQ-024 On out_valid && out_ready, the block SHALL return to IDLE; a new request SHALL NOT be accepted in that same cycle. Minimum initiation interval is WORDS+2 cycles.
REQ-025 Outside CALC, add_a, add_b and add_cin SHALL be driven 0.
REQ-026 in_valid in CALC or DONE SHALL be ignored, and a/b/cin changes SHALL NOT affect the operation in flight.
REQ-027 The result SHALL equal (a + b + cin) mod 2^W, with cout the carry out of bit W-1, including all-ones + 1 wrap to 0 with cout=1.

Reset
REQ-028 While rst_n=0, state SHALL be IDLE, k=0, the carry register 0, sum=0, cout=0, ovf=0 and out_valid=0; in_ready SHALL be 1 once rst_n=1.
REQ-029 Reset asserted mid-CALC or in DONE SHALL abort the operation immediately, with no partial result ever presented.

Configuration
REQ-030 With macro SEQ_ADD_OVF_EN defined, ovf SHALL be registered with the final word as (a[W-1]==b[W-1]) && (sum[W-1]!=a[W-1]), using registered operands.
REQ-031 Without SEQ_ADD_OVF_EN, ovf SHALL be tied to 0, no overflow logic SHALL be present, and all other behaviour SHALL be identical.

Verification
REQ-032 WORDS=2, a=0x0000FFFF, b=0x00000001, cin=0 -> add_cin=1 on the second CALC cycle; sum=0x00010000, cout=0, out_valid exactly 2 cycles after acceptance.
REQ-033 WORDS=2, a=0xFFFFFFFF, b=0, cin=1 -> sum=0x00000000, cout=1.
REQ-034 OVF build, WORDS=2, a=0x7FFFFFFF, b=1, cin=0 -> sum=0x80000000, ovf=1, cout=0. Non-OVF build with the same stimulus -> ovf=0.
REQ-035 Result held with out_ready=0 for 5 cycles while in_valid toggles with new operands -> sum/cout unchanged; in_ready=0 throughout; the first result is delivered.
REQ-036 Reset pulse during the first CALC cycle of a=0x12345678, b=0x11111111 -> all outputs 0 and state IDLE. A following request a=3, b=4 -> sum=7.
REQ-037 WORDS=4, a=0x0000FFFFFFFFFFFF, b=1 -> carry ripples across 3 words; sum=0x0001000000000000, out_valid 4 cycles after acceptance.
